// File: rtl/mem_access_pkg.sv
// Shared types for the data-memory access unit: size codes, FSM state and
// the data-bus request/response records.
package mem_access_pkg;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } mem_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // Sizes above a dword are treated as misaligned so they never reach the bus.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [2:0] msize);
    logic mis;
    case (msize)
      MSIZE1:  mis = 1'b0;
      MSIZE2:  mis = addr_lo[0];
      MSIZE4:  mis = |addr_lo[1:0];
      MSIZE8:  mis = |addr_lo;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus handshake between the access unit (master) and memory (slave).
interface mem_access_if;
  import mem_access_pkg::*;

  dbus_req_t  req;
  dbus_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/mem_access_strobe_gen.sv
// Byte-lane strobe, lane-shifted store data and alignment check for one op.
module mem_strobe_gen
  import mem_access_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  logic [2:0]  msize,
  input  logic        write,
  input  logic [63:0] wdata,
  output logic [7:0]  strobe,
  output logic [63:0] data,
  output logic        misalign
);

  always_comb begin
    strobe = 8'h00;
    if (write) begin
      case (msize)
        MSIZE1:  strobe = 8'h01 << addr_lo;
        MSIZE2:  strobe = 8'h03 << {addr_lo[2:1], 1'b0};
        MSIZE4:  strobe = 8'h0F << {addr_lo[2], 2'b00};
        MSIZE8:  strobe = 8'hFF;
        default: strobe = 8'h00;
      endcase
    end
  end

  assign data     = wdata << {addr_lo, 3'b000};
  assign misalign = is_misaligned(addr_lo, msize);

endmodule

// File: rtl/mem_access.sv
// Sequential load/store unit: runs the data-bus handshake, stalls the core
// and hands the raw load word plus its lane info to the extractor.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_msize,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  mem_access_if.master      dbus,
  output logic [DATA_W-1:0] ld_raw,
  output logic [2:0]        ld_addr,
  output logic [2:0]        ld_msize,
  output logic              ld_unsigned,
  output logic              done,
  output logic              misalign,
  output logic              stall
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        msize_q, msize_d;
  logic              write_q, write_d;
  logic              uns_q, uns_d;
  logic [7:0]        strobe_q, strobe_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ld_raw_q, ld_raw_d;
  logic              dreq_valid_q, dreq_valid_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;

  logic [7:0]        gen_strobe;
  logic [DATA_W-1:0] gen_data;
  logic              gen_misalign;

  // Lane shaping is done on the incoming request so the bus fields are flops.
  mem_strobe_gen u_strobe_gen (
    .addr_lo  (req_addr[2:0]),
    .msize    (req_msize),
    .write    (req_write),
    .wdata    (req_wdata),
    .strobe   (gen_strobe),
    .data     (gen_data),
    .misalign (gen_misalign)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    msize_d      = msize_q;
    write_d      = write_q;
    uns_d        = uns_q;
    strobe_d     = strobe_q;
    wdata_d      = wdata_q;
    ld_raw_d     = ld_raw_q;
    dreq_valid_d = 1'b0;
    done_d       = 1'b0;
    misalign_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          msize_d  = req_msize;
          write_d  = req_write;
          uns_d    = req_unsigned;
          strobe_d = gen_strobe;
          wdata_d  = gen_data;
          if (gen_misalign) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d      = S_REQ;
            dreq_valid_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (dbus.resp.addr_ok) begin
          if (dbus.resp.data_ok) begin
            if (!write_q) ld_raw_d = dbus.resp.data;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          dreq_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (dbus.resp.data_ok) begin
          if (!write_q) ld_raw_d = dbus.resp.data;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      msize_q      <= '0;
      write_q      <= 1'b0;
      uns_q        <= 1'b0;
      strobe_q     <= '0;
      wdata_q      <= '0;
      ld_raw_q     <= '0;
      dreq_valid_q <= 1'b0;
      done_q       <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      msize_q      <= msize_d;
      write_q      <= write_d;
      uns_q        <= uns_d;
      strobe_q     <= strobe_d;
      wdata_q      <= wdata_d;
      ld_raw_q     <= ld_raw_d;
      dreq_valid_q <= dreq_valid_d;
      done_q       <= done_d;
      misalign_q   <= misalign_d;
    end
  end

  assign dbus.req = '{valid: dreq_valid_q, addr: addr_q, size: msize_q,
                      strobe: strobe_q, data: wdata_q};

  assign ld_raw      = ld_raw_q;
  assign ld_addr     = addr_q[2:0];
  assign ld_msize    = msize_q;
  assign ld_unsigned = uns_q;
  assign done        = done_q;
  assign misalign    = misalign_q;
  assign stall       = ((state_q == S_IDLE) && req_valid) ||
                       (state_q == S_REQ) || (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access with a lane-level reference model and a
// scripted bus responder driven by per-op address/data delays.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [2:0]  req_msize = '0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = '0;
  logic [63:0] ld_raw;
  logic [2:0]  ld_addr;
  logic [2:0]  ld_msize;
  logic        ld_unsigned;
  logic        done;
  logic        misalign;
  logic        stall;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] ld_raw_m = '0;

  mem_access_if dbus ();

  mem_access dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_msize    (req_msize),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .dbus         (dbus),
    .ld_raw       (ld_raw),
    .ld_addr      (ld_addr),
    .ld_msize     (ld_msize),
    .ld_unsigned  (ld_unsigned),
    .done         (done),
    .misalign     (misalign),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int op_bytes(input logic [2:0] ms);
    return (ms <= 3'd3) ? (1 << ms) : 1;
  endfunction

  function automatic logic model_misaligned(input logic [63:0] addr, input logic [2:0] ms);
    return (ms > 3'd3) || ((int'(addr[2:0]) % op_bytes(ms)) != 0);
  endfunction

  // Lanes a..a+n-1 are written; loads write nothing.
  function automatic logic [7:0] model_strobe(input logic wr, input logic [63:0] addr, input logic [2:0] ms);
    logic [7:0] s;
    int a;
    s = '0;
    a = int'(addr[2:0]);
    for (int i = 0; i < 8; i++)
      s[i] = wr && (i >= a) && (i < a + op_bytes(ms));
    return s;
  endfunction

  function automatic logic [63:0] model_data(input logic [63:0] wd, input logic [63:0] addr);
    logic [63:0] d;
    int a;
    d = '0;
    a = int'(addr[2:0]);
    for (int i = 0; i < 8; i++)
      if (i >= a) d[8*i +: 8] = wd[8*(i-a) +: 8];
    return d;
  endfunction

  task automatic clear_bus();
    dbus.resp.addr_ok = 1'b0;
    dbus.resp.data_ok = 1'b0;
    dbus.resp.data    = '0;
  endtask

  // One op: da = REQ cycles before addr_ok, dd = WAIT cycles before data_ok
  // (0 = same cycle). Stops early after cycle abort_at when nonzero.
  task automatic do_op(input logic wr, input logic [63:0] addr, input logic [2:0] ms,
                       input logic uns, input logic [63:0] wd, input int da, input int dd,
                       input logic [63:0] rd, input int abort_at);
    logic mis;
    logic exp_valid;
    int   lat;
    mis = model_misaligned(addr, ms);
    lat = mis ? 2 : 3 + da + dd;
    @(posedge clk);
    #1;
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = addr;
    req_msize    = ms;
    req_unsigned = uns;
    req_wdata    = wd;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      exp_valid = !mis && (c >= 2) && (c <= 2 + da);
      check_eq("done", 64'(done), 64'(c == lat));
      check_eq("stall", 64'(stall), 64'(c < lat));
      check_eq("dreq_valid", 64'(dbus.req.valid), 64'(exp_valid));
      if (exp_valid) begin
        check_eq("dreq_addr", dbus.req.addr, addr);
        check_eq("dreq_size", 64'(dbus.req.size), 64'(ms));
        check_eq("dreq_strobe", 64'(dbus.req.strobe), 64'(model_strobe(wr, addr, ms)));
        check_eq("dreq_data", dbus.req.data, model_data(wd, addr));
      end
      if (c == lat) begin
        if (!mis && !wr) ld_raw_m = rd;
        check_eq("misalign", 64'(misalign), 64'(mis));
        check_eq("ld_raw", ld_raw, ld_raw_m);
        check_eq("ld_addr", 64'(ld_addr), 64'(addr[2:0]));
        check_eq("ld_msize", 64'(ld_msize), 64'(ms));
        check_eq("ld_unsigned", 64'(ld_unsigned), 64'(uns));
      end else begin
        check_eq("misalign_idle", 64'(misalign), 64'd0);
      end
      dbus.resp.addr_ok = !mis && (c == 2 + da);
      dbus.resp.data_ok = !mis && (((dd == 0) && (c == 2 + da)) || ((dd > 0) && (c == 2 + da + dd)));
      dbus.resp.data    = dbus.resp.data_ok ? rd : {$urandom, $urandom};
      if (c == abort_at) return;
    end
    clear_bus();
  endtask

  initial begin
    logic        wr, uns, aligned;
    logic [2:0]  ms;
    logic [63:0] addr, wd, rd;
    int          t0;

    clear_bus();
    #1;
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_dreq_valid", 64'(dbus.req.valid), 64'd0);
    check_eq("rst_ld_raw", ld_raw, 64'd0);
    check_eq("rst_misalign", 64'(misalign), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    $display("reset released");

    do_op(1'b0, 64'h1000, 3'd3, 1'b0, 64'h0, 0, 0, 64'h1122334455667788, 0);
    $display("op load dword @1000 ld_raw=%h", ld_raw);
    do_op(1'b1, 64'h2005, 3'd0, 1'b0, 64'hAB, 3, 2, 64'hDEADDEADDEADDEAD, 0);
    $display("op store byte @2005 ld_raw=%h", ld_raw);
    do_op(1'b1, 64'h3003, 3'd1, 1'b0, 64'hBEEF, 0, 0, 64'h0, 0);
    $display("op store half @3003 misalign=%0b", misalign);
    do_op(1'b0, 64'h4004, 3'd2, 1'b1, 64'h0, 0, 4, 64'hCAFEF00D_12345678, 0);
    $display("op load word @4004 ld_raw=%h", ld_raw);

    // Reset in the middle of a WAIT phase, then a stale data_ok in IDLE.
    do_op(1'b0, 64'h5000, 3'd3, 1'b0, 64'h0, 0, 5, 64'h5555AAAA5555AAAA, 4);
    #2;
    resetn    = 1'b0;
    req_valid = 1'b0;
    clear_bus();
    #1;
    check_eq("arst_dreq_valid", 64'(dbus.req.valid), 64'd0);
    check_eq("arst_dreq_addr", dbus.req.addr, 64'd0);
    check_eq("arst_stall", 64'(stall), 64'd0);
    check_eq("arst_done", 64'(done), 64'd0);
    check_eq("arst_ld_raw", ld_raw, 64'd0);
    check_eq("arst_ld_addr", 64'(ld_addr), 64'd0);
    ld_raw_m = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    dbus.resp.data_ok = 1'b1;
    dbus.resp.data    = 64'h0BAD0BAD0BAD0BAD;
    @(negedge clk);
    clear_bus();
    for (int i = 0; i < 3; i++) begin
      check_eq("stale_done", 64'(done), 64'd0);
      check_eq("stale_ld_raw", ld_raw, 64'd0);
      check_eq("stale_stall", 64'(stall), 64'd0);
      @(negedge clk);
    end
    $display("reset-in-wait and stale response done");

    t0 = n_cmp;
    for (int k = 0; k < 150; k++) begin
      wr      = 1'($urandom_range(0, 1));
      uns     = 1'($urandom_range(0, 1));
      ms      = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      addr    = {$urandom, $urandom};
      aligned = ($urandom_range(0, 3) != 0);
      if (aligned && ms <= 3'd3) addr = addr & ~(64'(op_bytes(ms)) - 64'd1);
      wd      = {$urandom, $urandom};
      rd      = {$urandom, $urandom};
      do_op(wr, addr, ms, uns, wd, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), rd, 0);
      $display("op %0d wr=%0b addr=%h ms=%0d done mis=%0b ld_raw=%h", k, wr, addr, ms, misalign, ld_raw);
    end
    $display("random ops made %0d comparisons", n_cmp - t0);

    req_valid = 1'b0;
    @(negedge clk);
    check_eq("final_done", 64'(done), 64'd0);
    check_eq("final_stall", 64'(stall), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Sequential data-memory access unit feeding the load-data extractor stage.
- Accepts one load/store per instruction from the core and runs the data-bus request/response handshake.
- Generates the byte strobe and the lane-shifted write data, and stalls the core until the access completes.
- For loads, presents the raw 64-bit bus word, the address low bits, the size and the signedness to the downstream extractor.

Parameters:
- ADDR_W, 64, address width; only 64 is supported.
- DATA_W, 64, bus data width; only 64 is supported (8 byte lanes).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core memory op pending; held high by the core until done.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_msize  in  3  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  load zero-extension flag; passed through.
- req_wdata  in  64  store data, right-aligned.
- dreq_valid  out  1  bus request valid.
- dreq_addr  out  64  bus address.
- dreq_size  out  3  bus size (= msize).
- dreq_strobe  out  8  byte write enables; 0 for loads.
- dreq_data  out  64  lane-shifted store data.
- dresp_addr_ok  in  1  bus accepted the request.
- dresp_data_ok  in  1  bus completed the access.
- dresp_data  in  64  load data, full aligned dword.
- ld_raw  out  64  captured dresp_data.
- ld_addr  out  3  req_addr[2:0] of the completed op.
- ld_msize  out  3  msize of the completed op.
- ld_unsigned  out  1  unsigned flag of the completed op.
- done  out  1  one-cycle completion pulse.
- misalign  out  1  valid with done; the op was not issued.
- stall  out  1  freeze the core's PC/writeback.

Behaviour:
- Reset (async, resetn = 0):
  - state = IDLE; all outputs 0.
  - Latched request fields and ld_raw cleared.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On req_valid, latch addr, msize, write, unsigned and wdata.
  - If misaligned or msize > 3, go to DONE with misalign = 1 and no bus traffic.
  - Otherwise go to REQ.
  - dresp_* are ignored in IDLE, so a stale response after reset is discarded.
- REQ:
  - dreq_valid = 1; all dreq_* fields are driven from latched values and stay stable until addr_ok.
  - addr_ok & data_ok in the same cycle: capture the data, go to DONE.
  - addr_ok only: go to WAIT.
  - Otherwise stay in REQ.
- WAIT:
  - dreq_valid = 0.
  - On data_ok: capture ld_raw = dresp_data (loads only; stores leave ld_raw unchanged), go to DONE.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - req_valid is ignored in DONE (the core advances on done; a one-cycle bubble prevents re-issuing a held op).
- stall = (IDLE & req_valid) | REQ | WAIT. stall is 0 in DONE.
- Misalignment rules:
  - half: addr[0] ≠ 0.
  - word: addr[1:0] ≠ 0.
  - dword: addr[2:0] ≠ 0.
  - byte: never misaligned.
- Strobe (stores only):
  - byte: 8'h01 << addr[2:0].
  - half: 8'h03 << {addr[2:1], 1'b0}.
  - word: 8'h0F << {addr[2], 2'b00}.
  - dword: 8'hFF.
- dreq_data = wdata << (8 × addr[2:0]); bits shifted out are dropped.
- dreq_addr = full latched address. The bus returns the aligned dword, and lane selection is done downstream.
- ld_* outputs hold their values from DONE until the next IDLE accept.
- Minimum latency: accept → REQ → DONE = 3 cycles when the bus answers combinationally.

Decomposition:
- Shared package (common):
  - msize constants MSIZE1/2/4/8.
  - mem_state_t enum.
  - dbus request/response struct typedefs matching the dreq_*/dresp_* fields.
- One combinational sub-module, mem_strobe_gen: inputs addr[2:0], msize, write, wdata; outputs strobe, shifted data, misalign.

Test Plan:
- Load dword @0x1000, addr_ok & data_ok same cycle with data 0x1122334455667788 → dreq_valid for 1 cycle, strobe 0x00, done in cycle 3, ld_raw = 0x1122334455667788, ld_addr = 0, stall high for 2 cycles.
- Store byte 0xAB @0x2005 → dreq_strobe = 0x20, dreq_data[47:40] = 0xAB; addr_ok delayed 3 cycles with fields stable throughout; data_ok 2 cycles later → done pulse, ld_raw unchanged.
- Store half 0xBEEF @0x3003 → misalign = 1 with done on cycle 2, dreq_valid never asserted.
- Load word @0x4004 unsigned, addr_ok then data_ok after 4 WAIT cycles → ld_addr = 4, ld_msize = 2, ld_unsigned = 1, stall continuous until DONE.
- resetn low while in WAIT → outputs 0 immediately; a data_ok arriving after reset in IDLE → no done, ld_raw stays 0.
- req_valid held high through DONE → exactly one bus request and one done per op; the next request is accepted only on the cycle after DONE.
